pool_relu: RTL and testbench

POOL_RELU -- requirements
Module: pool_relu

---
 rtl/pool_relu_pkg.sv | 12 +
 rtl/pool_relu_if.sv | 11 +
 rtl/pool_relu_relu_max.sv | 26 ++
 rtl/pool_relu.sv | 102 ++++++++++
 tb/tb_pool_relu.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/pool_relu_pkg.sv
// Shared constants for the pool_relu coprocessor block: FSM encoding and state type.
package pool_relu_pkg;

  localparam logic ST_FIRST = 1'b0;
  localparam logic ST_ACCUM = 1'b1;

  typedef enum logic {
    FIRST = ST_FIRST,
    ACCUM = ST_ACCUM
  } pool_state_t;

endpackage

// File: rtl/pool_relu_if.sv
// Valid/ready stream carrying one signed sample per transfer.
interface pool_relu_if #(
  parameter int NUM_WIDTH = 16
) ();
  logic                 val;
  logic [NUM_WIDTH-1:0] data;
  logic                 rdy;

  modport master (output val, output data, input rdy);
  modport slave  (input val, input data, output rdy);
endinterface

// File: rtl/pool_relu_relu_max.sv
// Combinational ReLU clamp followed by a signed running-max compare.
module relu_max #(
  parameter int NUM_WIDTH = 16
) (
  input  logic [NUM_WIDTH-1:0] acc,
  input  logic [NUM_WIDTH-1:0] x,
  input  logic                 cfg_relu,
  input  logic                 first,
  output logic [NUM_WIDTH-1:0] nxt
);

  logic [NUM_WIDTH-1:0] r;

  // A window's first sample loads directly; later samples keep the larger signed value.
  always_comb begin
    r = (cfg_relu && x[NUM_WIDTH-1]) ? '0 : x;
    if (first) begin
      nxt = r;
    end else if ($signed(r) > $signed(acc)) begin
      nxt = r;
    end else begin
      nxt = acc;
    end
  end

endmodule

// File: rtl/pool_relu.sv
// Max-pooling with optional ReLU over a programmable window, one result per window.
module pool_relu
  import pool_relu_pkg::*;
#(
  parameter int NUM_WIDTH = 16,
  parameter int POOL_MAX  = 4,
  parameter int CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_relu,
  input  logic [CNT_WIDTH-1:0] cfg_pool,
  pool_relu_if.slave           up,
  pool_relu_if.master          dn
);

  localparam logic [CNT_WIDTH-1:0] POOL_MAX_C = CNT_WIDTH'(POOL_MAX);
  localparam logic [CNT_WIDTH-1:0] ONE_C      = CNT_WIDTH'(1);

  pool_state_t          state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH:0]   cnt_inc;
  logic [CNT_WIDTH-1:0] w_eff;
  logic [NUM_WIDTH-1:0] acc_q, acc_d, max_nxt;
  logic [NUM_WIDTH-1:0] dn_data_q;
  logic                 dn_val_q;
  logic                 rdy;
  logic                 in_xfer;
  logic                 close;

  // The single output register may be refilled in the same cycle it drains.
  assign rdy      = ~dn_val_q | dn.rdy;
  assign up.rdy   = rdy;
  assign dn.val   = dn_val_q;
  assign dn.data  = dn_data_q;
  assign in_xfer  = up.val & rdy;
  assign cnt_inc  = {1'b0, cnt_q} + {{CNT_WIDTH{1'b0}}, 1'b1};
  assign close    = cnt_inc >= {1'b0, w_eff};

  // Clamp the requested window into 1..POOL_MAX.
  always_comb begin
    if (cfg_pool == '0) begin
      w_eff = ONE_C;
    end else if (cfg_pool > POOL_MAX_C) begin
      w_eff = POOL_MAX_C;
    end else begin
      w_eff = cfg_pool;
    end
  end

  relu_max #(.NUM_WIDTH(NUM_WIDTH)) u_relu_max (
    .acc      (acc_q),
    .x        (up.data),
    .cfg_relu (cfg_relu),
    .first    (state_q == FIRST),
    .nxt      (max_nxt)
  );

  // Next-state logic: only an accepted sample advances the window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    if (in_xfer) begin
      acc_d = max_nxt;
      if (close) begin
        state_d = FIRST;
        cnt_d   = '0;
      end else begin
        state_d = ACCUM;
        cnt_d   = cnt_inc[CNT_WIDTH-1:0];
      end
    end
  end

  // Window state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FIRST;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  // Output register: a closing sample overwrites, a bare drain clears valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_val_q  <= 1'b0;
      dn_data_q <= '0;
    end else if (in_xfer && close) begin
      dn_val_q  <= 1'b1;
      dn_data_q <= max_nxt;
    end else if (dn_val_q && dn.rdy) begin
      dn_val_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool_relu.sv
// Self-checking bench for pool_relu: directed scenarios plus randomized traffic
// against a window-list reference model.
module tb_pool_relu;

  localparam int NW = 16;
  localparam int PM = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_relu = 1'b0;
  logic [CW-1:0] cfg_pool = '0;

  pool_relu_if #(.NUM_WIDTH(NW)) up_bus ();
  pool_relu_if #(.NUM_WIDTH(NW)) dn_bus ();

  pool_relu #(.NUM_WIDTH(NW), .POOL_MAX(PM), .CNT_WIDTH(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_relu (cfg_relu),
    .cfg_pool (cfg_pool),
    .up       (up_bus.slave),
    .dn       (dn_bus.master)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // model state
  int win[$];
  bit exp_val = 0;
  int exp_data = 0;
  int got[$];
  bit last_acc = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int relu_of(input int x, input bit relu);
    return (relu && x < 0) ? 0 : x;
  endfunction

  function automatic int weff(input int p);
    if (p == 0) return 1;
    if (p > PM) return PM;
    return p;
  endfunction

  // One clock: check handshake at negedge, update model, check outputs after posedge.
  task automatic cycle();
    bit exp_rdy, in_x, out_x, closing;
    int m;
    @(negedge clk);
    exp_rdy = !exp_val || dn_bus.rdy;
    chk("up_rdy", int'(up_bus.rdy), int'(exp_rdy));
    in_x  = up_bus.val && exp_rdy;
    out_x = exp_val && dn_bus.rdy;
    if (dn_bus.val && dn_bus.rdy) got.push_back(int'($signed(dn_bus.data)));
    closing = 0;
    if (in_x) begin
      win.push_back(relu_of(int'($signed(up_bus.data)), cfg_relu));
      if (win.size() >= weff(int'(cfg_pool))) begin
        m = win[0];
        foreach (win[i]) if (win[i] > m) m = win[i];
        win.delete();
        closing = 1;
      end
    end
    if (closing) begin
      exp_val = 1;
      exp_data = m;
    end else if (out_x) begin
      exp_val = 0;
    end
    last_acc = in_x;
    @(posedge clk);
    #1;
    chk("dn_val", int'(dn_bus.val), int'(exp_val));
    if (exp_val) chk("dn_data", int'($signed(dn_bus.data)), exp_data);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_dn_val", int'(dn_bus.val), 0);
    chk("rst_dn_data", int'(dn_bus.data), 0);
    chk("rst_up_rdy", int'(up_bus.rdy), 1);
    win.delete();
    exp_val = 0;
    exp_data = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic feed(input int v);
    int budget;
    up_bus.val = 1'b1;
    up_bus.data = NW'(v);
    budget = 50;
    do begin
      cycle();
      budget--;
    end while (!last_acc && budget > 0);
    if (!last_acc) chk("feed_timeout", 0, 1);
    up_bus.val = 1'b0;
  endtask

  task automatic drain(input int n);
    up_bus.val = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic chk_got(input string tag, input int exp[$]);
    chk({tag, "_count"}, got.size(), exp.size());
    foreach (exp[i]) begin
      if (i < got.size()) chk(tag, got[i], exp[i]);
    end
    got.delete();
  endtask

  initial begin
    int q[$];
    up_bus.val = 1'b0;
    up_bus.data = '0;
    dn_bus.rdy = 1'b1;
    #2;
    chk("rst_dn_val", int'(dn_bus.val), 0);
    chk("rst_up_rdy", int'(up_bus.rdy), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // relu on, window 2
    cfg_pool = 3'd2; cfg_relu = 1'b1;
    q = '{5, -3, -7, -2};
    foreach (q[i]) feed(q[i]);
    drain(2);
    chk_got("relu_w2", '{5, 0});

    // relu off, extremes
    cfg_relu = 1'b0;
    q = '{-7, -2, 32767, -32768};
    foreach (q[i]) feed(q[i]);
    drain(2);
    chk_got("norelu_w2", '{-2, 32767});

    // window 1, back-to-back
    cfg_pool = 3'd1;
    q = '{1, 2, 3, 4};
    foreach (q[i]) feed(q[i]);
    drain(2);
    chk_got("w1", '{1, 2, 3, 4});

    // backpressure with window 4
    cfg_pool = 3'd4;
    q = '{3, 11, -4, 6};
    foreach (q[i]) feed(q[i]);
    dn_bus.rdy = 1'b0;
    up_bus.val = 1'b1;
    up_bus.data = NW'(20);
    repeat (4) cycle();
    chk("stall_rdy", int'(up_bus.rdy), 0);
    chk("stall_hold", int'($signed(dn_bus.data)), 11);
    dn_bus.rdy = 1'b1;
    q = '{20, -9, 33, 7};
    foreach (q[i]) feed(q[i]);
    drain(2);
    chk_got("backpressure", '{11, 33});

    // reset mid-window
    cfg_pool = 3'd3;
    feed(9); feed(4);
    do_reset();
    q = '{1, 2, 3};
    foreach (q[i]) feed(q[i]);
    drain(2);
    chk_got("reset_mid", '{3});

    // window clamping
    cfg_pool = 3'd0;
    for (int i = 1; i <= 8; i++) feed(i);
    drain(2);
    chk_got("w0", '{1, 2, 3, 4, 5, 6, 7, 8});
    cfg_pool = 3'd7;
    for (int i = 1; i <= 8; i++) feed(i);
    drain(2);
    chk_got("w7", '{4, 8});

    // randomized traffic with per-cycle config changes
    for (int i = 0; i < 1500; i++) begin
      up_bus.val  = ($urandom_range(0, 3) != 0);
      up_bus.data = NW'($urandom);
      dn_bus.rdy  = ($urandom_range(0, 2) != 0);
      cfg_relu    = 1'($urandom);
      if ($urandom_range(0, 15) == 0) cfg_pool = CW'($urandom);
      if ($urandom_range(0, 199) == 0) do_reset();
      else cycle();
    end
    got.delete();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
